// File: rtl/dmi_responder.sv
// DMI responder: turns one-cycle DMI request strobes from the debug transport into
// held req/ack transactions on the debug-register bus, and reports per-operation and sticky status.
module dmi_responder #(
    parameter int AWIDTH  = 7,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dmi_reg_en,
    input  logic              dmi_reg_wr_en,
    input  logic [AWIDTH-1:0] dmi_reg_addr,
    input  logic [31:0]       dmi_reg_wdata,
    input  logic              dmi_hard_reset,
    output logic [31:0]       dmi_reg_rdata,
    output logic [1:0]        rd_status,
    output logic [1:0]        dmi_stat,
    output logic              req_o,
    output logic              we_o,
    output logic [AWIDTH-1:0] addr_o,
    output logic [31:0]       wdata_o,
    input  logic              ack_i,
    input  logic              err_i,
    input  logic [31:0]       rdata_i
);

    localparam int            CW       = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK   = 2'd0;
    localparam logic [1:0] ST_ERR  = 2'd2;
    localparam logic [1:0] ST_BUSY = 2'd3;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    res_status;

    logic accept, bus_ok, bus_err, timed_out, complete, overlap;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latches are inferred.
        state_nxt = state;
        accept    = 1'b0;
        bus_ok    = 1'b0;
        bus_err   = 1'b0;
        timed_out = 1'b0;
        overlap   = 1'b0;

        case (state)
            IDLE: begin
                accept = dmi_reg_en && (dmi_stat == ST_OK);
                if (accept) state_nxt = BUSY;
            end
            BUSY: begin
                // err_i beats ack_i; any bus completion beats the timeout in the same cycle.
                bus_err   = err_i;
                bus_ok    = ack_i && !err_i;
                timed_out = !ack_i && !err_i && (cnt == CNT_LAST);
                overlap   = dmi_reg_en;
                if (bus_err || bus_ok || timed_out) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // Hard reset abandons everything, including a strobe arriving with it.
        if (dmi_hard_reset) begin
            state_nxt = IDLE;
            accept    = 1'b0;
            overlap   = 1'b0;
        end
    end

    assign complete  = bus_ok || bus_err || timed_out;
    assign rd_status = (state == BUSY) ? ST_BUSY : res_status;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_o         <= 1'b0;
            we_o          <= 1'b0;
            addr_o        <= '0;
            wdata_o       <= '0;
            dmi_reg_rdata <= '0;
            res_status    <= ST_OK;
            dmi_stat      <= ST_OK;
            cnt           <= '0;
        end else if (dmi_hard_reset) begin
            // Read data survives a hard reset; the debugger may still want it.
            req_o      <= 1'b0;
            res_status <= ST_OK;
            dmi_stat   <= ST_OK;
            cnt        <= '0;
        end else begin
            if (accept) begin
                req_o   <= 1'b1;
                we_o    <= dmi_reg_wr_en;
                addr_o  <= dmi_reg_addr;
                wdata_o <= dmi_reg_wdata;
                cnt     <= '0;
            end else if (complete) begin
                req_o <= 1'b0;
                cnt   <= '0;
                if (bus_ok) begin
                    res_status <= ST_OK;
                    if (!we_o) dmi_reg_rdata <= rdata_i;
                end else begin
                    res_status <= ST_ERR;
                end
            end else if (state == BUSY) begin
                cnt <= cnt + CW'(1);
            end

            if (overlap)
                dmi_stat <= ST_BUSY;
            else if ((bus_err || timed_out) && dmi_stat == ST_OK)
                dmi_stat <= ST_ERR;
        end
    end

endmodule

// File: tb/tb_dmi_responder.sv
// Self-checking bench for dmi_responder: directed scenarios plus randomized
// transactions scored against a transaction-level model of the status rules.
module tb_dmi_responder;

    localparam int AW = 7;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dmi_reg_en = 1'b0;
    logic          dmi_reg_wr_en = 1'b0;
    logic [AW-1:0] dmi_reg_addr = '0;
    logic [31:0]   dmi_reg_wdata = '0;
    logic          dmi_hard_reset = 1'b0;
    logic [31:0]   dmi_reg_rdata;
    logic [1:0]    rd_status;
    logic [1:0]    dmi_stat;
    logic          req_o;
    logic          we_o;
    logic [AW-1:0] addr_o;
    logic [31:0]   wdata_o;
    logic          ack_i = 1'b0;
    logic          err_i = 1'b0;
    logic [31:0]   rdata_i = '0;

    dmi_responder #(.AWIDTH(AW), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dmi_reg_en     (dmi_reg_en),
        .dmi_reg_wr_en  (dmi_reg_wr_en),
        .dmi_reg_addr   (dmi_reg_addr),
        .dmi_reg_wdata  (dmi_reg_wdata),
        .dmi_hard_reset (dmi_hard_reset),
        .dmi_reg_rdata  (dmi_reg_rdata),
        .rd_status      (rd_status),
        .dmi_stat       (dmi_stat),
        .req_o          (req_o),
        .we_o           (we_o),
        .addr_o         (addr_o),
        .wdata_o        (wdata_o),
        .ack_i          (ack_i),
        .err_i          (err_i),
        .rdata_i        (rdata_i)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model of the externally visible status registers.
    logic [31:0] m_rdata  = '0;
    logic [1:0]  m_status = '0;
    logic [1:0]  m_stat   = '0;

    localparam int RESP_ACK  = 0;
    localparam int RESP_ERR  = 1;
    localparam int RESP_NONE = 2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_check(input string tag);
        check({tag, "_req"},    32'(req_o),     32'd0);
        check({tag, "_status"}, 32'(rd_status), 32'(m_status));
        check({tag, "_stat"},   32'(dmi_stat),  32'(m_stat));
        check({tag, "_rdata"},  dmi_reg_rdata,  m_rdata);
    endtask

    // Called at a negedge; issues one DMI strobe and plays the bus side.
    // lat: req cycle index at which the bus answers; ov_k: req cycle carrying a second strobe (-1: none).
    task automatic txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                       input int resp, input int lat, input int ov_k, input logic [31:0] rd);
        int  exp_cycles;
        int  seen;
        bit  ok_outcome;
        dmi_reg_en    = 1'b1;
        dmi_reg_wr_en = wr;
        dmi_reg_addr  = addr;
        dmi_reg_wdata = wd;
        @(negedge clk);
        dmi_reg_en    = 1'b0;
        dmi_reg_wr_en = 1'($urandom);
        dmi_reg_addr  = AW'($urandom);
        dmi_reg_wdata = $urandom;
        if (m_stat != 2'd0) begin
            check("rej_req", 32'(req_o), 32'd0);
            check("rej_status", 32'(rd_status), 32'(m_status));
            @(negedge clk);
            check("rej_req_later", 32'(req_o), 32'd0);
            return;
        end
        check("req_rise", 32'(req_o), 32'd1);
        check("req_addr", 32'(addr_o), 32'(addr));
        check("req_we", 32'(we_o), 32'(wr));
        if (wr) check("req_wdata", wdata_o, wd);
        check("busy_status", 32'(rd_status), 32'd3);

        ok_outcome = (resp != RESP_NONE) && (lat <= TO - 1);
        exp_cycles = ok_outcome ? lat + 1 : TO;
        seen = 0;
        for (int k = 0; k < TO + 3; k++) begin
            if (!req_o) break;
            seen++;
            if (addr_o !== addr || we_o !== wr) check("req_hold", 32'(addr_o), 32'(addr));
            ack_i         = (resp == RESP_ACK) && (k == lat);
            err_i         = (resp == RESP_ERR) && (k == lat);
            rdata_i       = (k == lat) ? rd : $urandom;
            dmi_reg_en    = (k == ov_k);
            dmi_reg_wr_en = 1'($urandom);
            @(negedge clk);
            ack_i      = 1'b0;
            err_i      = 1'b0;
            dmi_reg_en = 1'b0;
        end
        check("req_cycles", 32'(seen), 32'(exp_cycles));

        if (ok_outcome && resp == RESP_ACK) begin
            m_status = 2'd0;
            if (!wr) m_rdata = rd;
        end else begin
            m_status = 2'd2;
            if (m_stat == 2'd0) m_stat = 2'd2;
        end
        if (ov_k >= 0 && ov_k < exp_cycles) m_stat = 2'd3;
        idle_check("done");
    endtask

    task automatic hard_reset();
        dmi_hard_reset = 1'b1;
        @(negedge clk);
        dmi_hard_reset = 1'b0;
        m_stat   = 2'd0;
        m_status = 2'd0;
        idle_check("hreset");
    endtask

    // A bus response while idle must change nothing.
    task automatic stray(input bit is_err);
        ack_i   = !is_err;
        err_i   = is_err;
        rdata_i = $urandom;
        @(negedge clk);
        ack_i = 1'b0;
        err_i = 1'b0;
        idle_check("stray");
    endtask

    // Hard reset together with a new strobe while a read is outstanding; expects m_stat == 0.
    task automatic abort(input int k_abort);
        dmi_reg_en    = 1'b1;
        dmi_reg_wr_en = 1'b0;
        dmi_reg_addr  = AW'($urandom);
        @(negedge clk);
        dmi_reg_en = 1'b0;
        for (int k = 0; k < k_abort; k++) begin
            check("abort_busy", 32'(req_o), 32'd1);
            @(negedge clk);
        end
        dmi_hard_reset = 1'b1;
        dmi_reg_en     = 1'b1;
        @(negedge clk);
        dmi_hard_reset = 1'b0;
        dmi_reg_en     = 1'b0;
        m_stat   = 2'd0;
        m_status = 2'd0;
        idle_check("abort");
        @(negedge clk);
        check("abort_no_new_req", 32'(req_o), 32'd0);
        stray(1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        idle_check("reset");
        check("reset_we", 32'(we_o), 32'd0);
        check("reset_addr", 32'(addr_o), 32'd0);
        check("reset_wdata", wdata_o, 32'd0);

        // Read with ack on the last allowed cycle, then a write with immediate ack.
        txn(1'b0, 7'h11, 32'd0, RESP_ACK, 3, -1, 32'hCAFE_F00D);
        txn(1'b1, 7'h10, 32'h8000_0001, RESP_ACK, 0, -1, 32'h1234_5678);
        // Error response, sticky rejection, clear and retry.
        txn(1'b0, 7'h05, 32'd0, RESP_ERR, 1, -1, 32'h0);
        txn(1'b0, 7'h06, 32'd0, RESP_ACK, 0, -1, 32'h1111_1111);
        hard_reset();
        txn(1'b0, 7'h07, 32'd0, RESP_ACK, 0, -1, 32'h2222_2222);
        // Timeout, then a late ack.
        txn(1'b0, 7'h08, 32'd0, RESP_NONE, 0, -1, 32'h0);
        @(negedge clk);
        stray(1'b0);
        hard_reset();
        // Overlapping strobe in the first busy cycle.
        txn(1'b0, 7'h09, 32'd0, RESP_ACK, 2, 0, 32'h3333_3333);
        hard_reset();
        abort(1);

        // Async reset in the middle of a transaction.
        dmi_reg_en = 1'b1;
        @(negedge clk);
        dmi_reg_en = 1'b0;
        check("pre_rst_req", 32'(req_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        m_rdata = '0; m_status = '0; m_stat = '0;
        idle_check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            int op;
            op = int'($urandom_range(0, 9));
            if (op <= 5)
                txn(1'($urandom), AW'($urandom), $urandom, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, TO + 1)),
                    ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, TO - 1)) : -1,
                    $urandom);
            else if (op == 6 || (op == 7 && m_stat != 2'd0))
                hard_reset();
            else if (op == 7)
                abort(int'($urandom_range(0, TO - 1)));
            else
                stray(1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmi_responder.md
Name: dmi_responder

Overview:
- Target-side end of the DMI link. Accepts single-cycle DMI request pulses from the JTAG debug transport and turns them into a held request/acknowledge transaction on a generic debug-register bus.
- Captures read data and returns it with per-operation status and sticky error status for the transport's next DR capture.
- Sits between the BSCAN-based DTM and the debug module register file, in the core clock domain.

Parameters:
- AWIDTH, 7, DMI address width.
- TIMEOUT, 255, bus cycles with req_o high and no ack_i/err_i before abort; range 1..65535; counter width $clog2(TIMEOUT+1).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- dmi_reg_en  in  1  one-cycle DMI request strobe.
- dmi_reg_wr_en  in  1  qualifies dmi_reg_en: 1 = write, 0 = read.
- dmi_reg_addr  in  AWIDTH  request address.
- dmi_reg_wdata  in  32  write data.
- dmi_hard_reset  in  1  one-cycle pulse: abort and clear all status.
- dmi_reg_rdata  out  32  last read data.
- rd_status  out  2  operation status to transport.
- dmi_stat  out  2  sticky error status.
- req_o  out  1  bus request, held until completion.
- we_o  out  1  bus write enable.
- addr_o  out  AWIDTH  bus address.
- wdata_o  out  32  bus write data.
- ack_i  in  1  bus success completion.
- err_i  in  1  bus error completion.
- rdata_i  in  32  bus read data, valid with ack_i.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE.
  - req_o=0, we_o=0, addr_o=0, wdata_o=0.
  - dmi_reg_rdata=0, result status=0, dmi_stat=0, timeout counter=0.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - A request is accepted when dmi_reg_en=1 and dmi_stat=0 in cycle N.
  - On acceptance, latch we_o/addr_o/wdata_o and assert req_o from cycle N+1; go to BUSY.
  - If dmi_stat!=0, dmi_reg_en is ignored with no bus activity.
- BUSY:
  - req_o, we_o, addr_o and wdata_o stay stable until completion.
  - The counter increments each cycle while req_o=1 and no completion is present.
- Completion in cycle M (ack_i, err_i, or counter==TIMEOUT-1 with neither) has these effects at M+1:
  - req_o=0, state IDLE, counter cleared.
  - ack_i: result status=0. If it was a read, dmi_reg_rdata<=rdata_i; a write leaves dmi_reg_rdata unchanged.
  - err_i or timeout: result status=2; dmi_reg_rdata unchanged. If dmi_stat==0, dmi_stat<=2.
  - If ack_i and err_i are both high, err_i wins.
  - If a completion and the timeout fall in the same cycle, the completion wins.
- Minimum turnaround: ack_i in the first req_o cycle gives a result visible 2 cycles after dmi_reg_en. The next request can be accepted in the cycle after req_o falls.
- rd_status is combinational: 2'b11 while BUSY, else the result status register.
- dmi_reg_en while BUSY:
  - The request is dropped and dmi_stat<=3 (overrides 0 or 2).
  - The outstanding transaction continues unaffected.
- dmi_stat stays set until dmi_hard_reset or rst_n. No request is accepted while it is nonzero.
- dmi_hard_reset=1 in cycle K, at K+1:
  - dmi_stat=0, result status=0, req_o=0, state IDLE, counter cleared.
  - Any outstanding bus transaction is abandoned; a late ack_i/err_i in IDLE is ignored.
  - dmi_reg_rdata is retained.
- dmi_reg_en in the same cycle as dmi_hard_reset: hard reset wins and the request is dropped.
- ack_i/err_i while IDLE: ignored, no state change.
- rst_n asserted mid-transaction: immediate return to reset values, including req_o=0.
- Inputs are in the clk domain; synchronisation and edge detection happen upstream.

Test Plan:
- Read: dmi_reg_en=1, wr_en=0, addr=7'h11. Bus returns ack_i with rdata_i=32'hCAFE_F00D 3 cycles after req_o rises. Required:
  - req_o rises at N+1 with addr_o=7'h11, we_o=0.
  - rd_status=3 while busy.
  - After ack: dmi_reg_rdata=32'hCAFE_F00D, rd_status=0, dmi_stat=0.
- Write: wr_en=1, addr=7'h10, wdata=32'h8000_0001, immediate ack_i. Required:
  - we_o=1, wdata_o=32'h8000_0001.
  - dmi_reg_rdata unchanged from the previous value.
  - rd_status=0 two cycles after the strobe.
- Error and sticky: read with err_i in response. Required:
  - rd_status=2, dmi_stat=2.
  - A subsequent dmi_reg_en produces no req_o.
  - A dmi_hard_reset pulse clears dmi_stat=0, rd_status=0; the next request is accepted.
- Timeout: TIMEOUT=4, bus never responds. Required:
  - req_o high exactly 4 cycles, then drops.
  - rd_status=2, dmi_stat=2.
  - ack_i arriving 2 cycles later is ignored.
- Overlap: second dmi_reg_en while BUSY. Required:
  - No second req_o.
  - dmi_stat=3 immediately after.
  - The first transaction still completes with its own status 0.
- Abort: dmi_hard_reset while req_o is high, together with a concurrent dmi_reg_en. Required:
  - req_o=0 next cycle, state IDLE.
  - No new request issued.
  - A subsequent late ack_i has no effect.
